grant_finish_unit: RTL

- Client-side endpoint of the 4-port grant network; the network's arbitrated, dst-routed grant output drives this block's input.
- Forwards each grant beat to the local client.
- Counts data beats and, on the last beat of any grant that needs acknowledgement, queues a Finish message.
- The Finish message goes back to the granting manager: header_dst = grant header_src, carrying manager_xact_id.

---
 rtl/grant_finish_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/grant_finish_unit.sv
// Client-side grant endpoint: forwards grant beats to the client and queues a
// Finish back to the granting manager on the last beat of grants that need one.
module grant_finish_unit #(
    parameter logic [1:0]  MY_ID        = 2'h0,
    parameter int unsigned DATA_BEATS   = 4,
    parameter int unsigned FINISH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    output logic        io_in_ready,
    input  logic        io_in_valid,
    input  logic [1:0]  io_in_bits_header_src,
    input  logic [1:0]  io_in_bits_header_dst,
    input  logic [2:0]  io_in_bits_payload_addr_beat,
    input  logic        io_in_bits_payload_client_xact_id,
    input  logic [1:0]  io_in_bits_payload_manager_xact_id,
    input  logic        io_in_bits_payload_is_builtin_type,
    input  logic [3:0]  io_in_bits_payload_g_type,
    input  logic [63:0] io_in_bits_payload_data,

    input  logic        io_out_ready,
    output logic        io_out_valid,
    output logic [2:0]  io_out_bits_addr_beat,
    output logic        io_out_bits_client_xact_id,
    output logic [1:0]  io_out_bits_manager_xact_id,
    output logic        io_out_bits_is_builtin_type,
    output logic [3:0]  io_out_bits_g_type,
    output logic [63:0] io_out_bits_data,

    input  logic        io_finish_ready,
    output logic        io_finish_valid,
    output logic [1:0]  io_finish_bits_header_src,
    output logic [1:0]  io_finish_bits_header_dst,
    output logic [1:0]  io_finish_bits_payload_manager_xact_id,

    output logic        io_dst_err
);

    localparam logic [2:0] LastBeat = 3'(DATA_BEATS - 1);
    localparam logic [2:0] Depth    = 3'(FINISH_DEPTH);
    localparam logic [1:0] PtrMax   = 2'(FINISH_DEPTH - 1);

    logic [2:0] beat_cnt_q, beat_cnt_d;
    logic [2:0] count_q, count_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic       dst_err_q, dst_err_d;
    // Entry = {header_src, manager_xact_id}; only the first FINISH_DEPTH slots are used.
    logic [3:0] fin_mem_q [4];

    logic multi, need_fin, last, enq_need, can_go, fire, enq, deq;

    always_comb begin
        multi = (io_in_bits_payload_is_builtin_type && io_in_bits_payload_g_type == 4'h5) ||
                (!io_in_bits_payload_is_builtin_type &&
                 (io_in_bits_payload_g_type == 4'h0 || io_in_bits_payload_g_type == 4'h1));
        need_fin = !(io_in_bits_payload_is_builtin_type && io_in_bits_payload_g_type == 4'h0);
        last     = !multi || (beat_cnt_q == LastBeat);
        enq_need = need_fin && last;
        // Full check uses the registered count, so a same-cycle dequeue cannot free a slot.
        can_go   = !enq_need || (count_q < Depth);
    end

    assign io_out_valid    = io_in_valid && can_go;
    assign io_in_ready     = io_out_ready && can_go && !reset;
    assign fire            = io_in_valid && io_in_ready;
    assign enq             = fire && enq_need;
    assign io_finish_valid = (count_q != 3'd0) && !reset;
    assign deq             = io_finish_valid && io_finish_ready;

    assign io_out_bits_addr_beat       = io_in_bits_payload_addr_beat;
    assign io_out_bits_client_xact_id  = io_in_bits_payload_client_xact_id;
    assign io_out_bits_manager_xact_id = io_in_bits_payload_manager_xact_id;
    assign io_out_bits_is_builtin_type = io_in_bits_payload_is_builtin_type;
    assign io_out_bits_g_type          = io_in_bits_payload_g_type;
    assign io_out_bits_data            = io_in_bits_payload_data;

    assign io_finish_bits_header_src              = MY_ID;
    assign io_finish_bits_header_dst              = fin_mem_q[rd_ptr_q][3:2];
    assign io_finish_bits_payload_manager_xact_id = fin_mem_q[rd_ptr_q][1:0];
    assign io_dst_err                             = dst_err_q;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dst_err_d  = dst_err_q;

        if (fire && multi) begin
            beat_cnt_d = last ? 3'd0 : beat_cnt_q + 3'd1;
        end
        if (fire && io_in_bits_header_dst != MY_ID) begin
            dst_err_d = 1'b1;
        end
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == PtrMax) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= 3'd0;
            count_q    <= 3'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            dst_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dst_err_q  <= dst_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            fin_mem_q[wr_ptr_q] <= {io_in_bits_header_src, io_in_bits_payload_manager_xact_id};
        end
    end

endmodule
